// File: rtl/ov7670_pixel_capture.sv
// rtl/ov7670_pixel_capture.sv - OV7670 byte-pair to RGB565 pixel capture with frame-buffer write port
//
// Purpose: registers the sensor bus, frames it with vsync/href, packs byte
// pairs into RGB565 pixels and emits one write strobe per pixel with a packed
// linear address. Only whole frames seen from a vsync pulse are captured.
//
// Ports:
//   pclk        sensor pixel clock (only clock)
//   reset       synchronous, active-high
//   vsync       sensor frame sync, high = vertical blank
//   href        sensor line valid
//   d           sensor data byte
//   pixel       RGB565 pixel, first byte in [15:8]
//   we          one-cycle write strobe, pixel/addr valid when high
//   addr        linear buffer address
//   frame_start one-cycle pulse when a captured frame begins
//   frame_done  one-cycle pulse when a captured frame ends
//   line_err    sticky per frame: some line ended on an odd byte count

module ov7670_pixel_capture #(
  parameter int HSIZE     = 160,
  parameter int VSIZE     = 120,
  parameter int ADDR_BITS = 15,
  parameter int XBITS     = 8,
  parameter int YBITS     = 7
) (
  input  logic                 pclk,
  input  logic                 reset,
  input  logic                 vsync,
  input  logic                 href,
  input  logic [7:0]           d,
  output logic [15:0]          pixel,
  output logic                 we,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic                 line_err
);

  typedef enum logic [1:0] {
    S_SYNC,
    S_BLANK,
    S_ACTIVE
  } state_t;

  localparam logic [XBITS-1:0] X_LIM = XBITS'(HSIZE);
  localparam logic [YBITS-1:0] Y_LIM = YBITS'(VSIZE);

  // Input register stage plus a second copy for edge detection.
  logic       vsync_r_q, href_r_q, vsync_rr_q, href_rr_q;
  logic [7:0] d_r_q;

  logic vs_rise, vs_fall, href_fall;

  state_t                 state_q, state_d;
  logic [XBITS-1:0]       x_q, x_d;
  logic [YBITS-1:0]       y_q, y_d;
  logic [ADDR_BITS-1:0]   addr_cnt_q, addr_cnt_d;
  logic                   phase_q, phase_d;
  logic [7:0]             hi_q, hi_d;
  logic [15:0]            pixel_q, pixel_d;
  logic                   we_q, we_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   frame_start_q, frame_start_d;
  logic                   frame_done_q, frame_done_d;
  logic                   line_err_q, line_err_d;

  assign vs_rise   = vsync_r_q & ~vsync_rr_q;
  assign vs_fall   = ~vsync_r_q & vsync_rr_q;
  assign href_fall = ~href_r_q & href_rr_q;

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    addr_cnt_d    = addr_cnt_q;
    phase_d       = phase_q;
    hi_d          = hi_q;
    pixel_d       = pixel_q;
    addr_d        = addr_q;
    line_err_d    = line_err_q;
    we_d          = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;

    case (state_q)
      S_SYNC: begin
        if (vsync_r_q) state_d = S_BLANK;
      end

      S_BLANK: begin
        x_d        = '0;
        y_d        = '0;
        addr_cnt_d = '0;
        phase_d    = 1'b0;
        if (vs_fall) begin
          frame_start_d = 1'b1;
          line_err_d    = 1'b0;
          state_d       = S_ACTIVE;
        end
      end

      S_ACTIVE: begin
        // ACTIVE is only entered with vsync_r low, so the first vsync_r high
        // seen here is always the rising edge. Any half-pixel is abandoned.
        if (vsync_r_q) begin
          frame_done_d = vs_rise;
          state_d      = S_BLANK;
        end else if (href_r_q) begin
          if (!phase_q) begin
            hi_d    = d_r_q;
            phase_d = 1'b1;
          end else begin
            if (x_q < X_LIM && y_q < Y_LIM) begin
              pixel_d    = {hi_q, d_r_q};
              addr_d     = addr_cnt_q;
              we_d       = 1'b1;
              addr_cnt_d = addr_cnt_q + 1'b1;
            end
            if (x_q != X_LIM) x_d = x_q + 1'b1;
            phase_d = 1'b0;
          end
        end else if (href_fall) begin
          if (phase_q) line_err_d = 1'b1;
          x_d     = '0;
          phase_d = 1'b0;
          if (y_q != Y_LIM) y_d = y_q + 1'b1;
        end
      end

      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      vsync_r_q     <= 1'b0;
      href_r_q      <= 1'b0;
      d_r_q         <= '0;
      vsync_rr_q    <= 1'b0;
      href_rr_q     <= 1'b0;
      state_q       <= S_SYNC;
      x_q           <= '0;
      y_q           <= '0;
      addr_cnt_q    <= '0;
      phase_q       <= 1'b0;
      hi_q          <= '0;
      pixel_q       <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      vsync_r_q     <= vsync;
      href_r_q      <= href;
      d_r_q         <= d;
      vsync_rr_q    <= vsync_r_q;
      href_rr_q     <= href_r_q;
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      addr_cnt_q    <= addr_cnt_d;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      pixel_q       <= pixel_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      line_err_q    <= line_err_d;
    end
  end

  assign pixel       = pixel_q;
  assign we          = we_q;
  assign addr        = addr_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign line_err    = line_err_q;

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// tb/tb_ov7670_pixel_capture.sv - self-checking bench for ov7670_pixel_capture

module tb_ov7670_pixel_capture;

  localparam int HSIZE     = 160;
  localparam int VSIZE     = 120;
  localparam int ADDR_BITS = 15;
  localparam int EW        = ADDR_BITS + 16;

  logic                 clk;
  logic                 reset;
  logic                 vsync;
  logic                 href;
  logic [7:0]           d;
  logic [15:0]          pixel;
  logic                 we;
  logic [ADDR_BITS-1:0] addr;
  logic                 frame_start;
  logic                 frame_done;
  logic                 line_err;

  ov7670_pixel_capture #(
    .HSIZE(HSIZE), .VSIZE(VSIZE), .ADDR_BITS(ADDR_BITS), .XBITS(8), .YBITS(7)
  ) dut (
    .pclk(clk), .reset(reset), .vsync(vsync), .href(href), .d(d),
    .pixel(pixel), .we(we), .addr(addr),
    .frame_start(frame_start), .frame_done(frame_done), .line_err(line_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Observed strobes and status pulses for the current frame.
  logic [EW-1:0] got_q[$];
  int fs_cnt, fd_cnt, fs_cyc, fd_cyc, first_we_cyc;

  always @(negedge clk) begin
    if (we) begin
      if (got_q.size() == 0) first_we_cyc = cyc;
      got_q.push_back({addr, pixel});
    end
    if (frame_start) begin fs_cnt++; fs_cyc = cyc; end
    if (frame_done)  begin fd_cnt++; fd_cyc = cyc; end
  end

  // Reference model state: expected writes of the frame (packed, address is
  // the write's position), line number, sticky error, and whether capture of
  // this frame is void (before the first vsync pulse or after a reset).
  logic [EW-1:0] exp_q[$];
  int m_y;
  bit m_err;
  bit m_dead;
  int fall_cyc, rise_cyc, b1_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic vs, input logic hr, input logic [7:0] dd);
    vsync = vs;
    href  = hr;
    d     = dd;
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int len, input int mode, input bit cut, input int rst_at);
    logic [7:0] b[$];
    logic [7:0] v;
    bit dead_before;
    dead_before = m_dead;
    for (int i = 0; i < len; i++) begin
      v = (mode == 0) ? 8'(i) : 8'($urandom_range(0, 255));
      b.push_back(v);
      if (m_y == 0 && i == 1) b1_cyc = cyc;
      if (i == rst_at) reset = 1'b1;
      step(1'b0, 1'b1, v);
      if (i == rst_at) begin
        reset = 1'b0;
        chk("rst_we", we, 0);
        chk("rst_addr", addr, 0);
        m_dead = 1'b1;
      end
    end
    // A pair whose second byte is still in the input register when reset is
    // sampled never reaches the output.
    if (!dead_before) begin
      for (int p = 0; p < len / 2; p++) begin
        if (p < HSIZE && m_y < VSIZE && (rst_at < 0 || 2 * p + 1 <= rst_at - 2))
          exp_q.push_back({ADDR_BITS'(exp_q.size()), b[2*p], b[2*p+1]});
      end
    end
    if (!cut) begin
      if (len % 2 == 1 && !m_dead) m_err = 1'b1;
      m_y++;
      repeat (4) step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
      chk("line_err_line", line_err, m_err);
    end
  endtask

  task automatic frame_begin();
    got_q.delete();
    exp_q.delete();
    fs_cnt = 0;
    fd_cnt = 0;
    m_y    = 0;
    m_err  = 1'b0;
    m_dead = 1'b0;
    fall_cyc = cyc;
    repeat (5) step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
    chk("fs_cnt", fs_cnt, 1);
    chk("fs_lat", fs_cyc, fall_cyc + 2);
    chk("line_err_clr", line_err, 0);
  endtask

  task automatic check_frame();
    logic [EW-1:0] hold_exp;
    int n;
    bit stop;
    chk("n_strobes", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    stop = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!stop) begin
        chk("addr_pixel", got_q[i], exp_q[i]);
        if (got_q[i] !== exp_q[i]) stop = 1'b1;
      end
    end
    chk("line_err_end", line_err, m_err);
    if (m_dead || exp_q.size() == 0) hold_exp = '0;
    else hold_exp = exp_q[exp_q.size()-1];
    chk("hold_addr_pixel", {addr, pixel}, hold_exp);
  endtask

  task automatic frame_end(input bit exp_fd, input bit hold_href);
    rise_cyc = cyc;
    for (int i = 0; i < 5; i++)
      step(1'b1, (i < 2) ? hold_href : 1'b0, 8'($urandom_range(0, 255)));
    chk("fd_cnt", fd_cnt, exp_fd);
    if (exp_fd) chk("fd_lat", fd_cyc, rise_cyc + 2);
    check_frame();
  endtask

  initial begin
    reset = 1'b1;
    vsync = 1'b0;
    href  = 1'b0;
    d     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pixel", pixel, 0);
    chk("rst_we", we, 0);
    chk("rst_addr", addr, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_line_err", line_err, 0);
    reset = 1'b0;

    // Partial frame after reset: no vsync pulse yet, nothing may be written.
    got_q.delete();
    exp_q.delete();
    fs_cnt = 0; fd_cnt = 0; m_y = 0; m_err = 1'b0; m_dead = 1'b1;
    repeat (3) send_line(20, 1, 1'b0, -1);
    frame_end(1'b0, 1'b0);
    chk("partial_fs", fs_cnt, 0);

    // Full frame with 5 surplus lines, byte value = index mod 256.
    frame_begin();
    for (int y = 0; y < VSIZE + 5; y++) send_line(2 * HSIZE, 0, 1'b0, -1);
    frame_end(1'b1, 1'b0);
    chk("full_count", got_q.size(), HSIZE * VSIZE);
    if (got_q.size() >= 2) begin
      chk("first_pixel", got_q[0][15:0], 16'h0001);
      chk("second_pixel", got_q[1][15:0], 16'h0203);
    end
    chk("pixel_latency", first_we_cyc, b1_cyc + 2);

    // Over-long line, odd line, then random short lines.
    frame_begin();
    send_line(330, 1, 1'b0, -1);
    send_line(321, 1, 1'b0, -1);
    repeat (8) send_line($urandom_range(1, 60), 1, 1'b0, -1);
    frame_end(1'b1, 1'b0);

    // Reset at line 60 byte 100; the rest of the frame is void.
    frame_begin();
    for (int y = 0; y < 60; y++) send_line(110, 1, 1'b0, -1);
    send_line(110, 1, 1'b0, 100);
    send_line(110, 1, 1'b0, -1);
    frame_end(1'b0, 1'b0);
    chk("reset_frame_count", got_q.size(), 60 * 55 + 49);

    // Following frame restarts at 0; vsync rises mid-pixel with href high.
    frame_begin();
    repeat (3) send_line(2 * $urandom_range(5, 15), 1, 1'b0, -1);
    send_line(7, 1, 1'b1, -1);
    frame_end(1'b1, 1'b1);
    if (got_q.size() >= 1) chk("restart_addr0", got_q[0][EW-1:16], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
